// File: rtl/adc_capture_ctrl.sv
// adc_capture_ctrl: dual-channel ADC capture controller with AXI-Stream style output.
//
// Arm with a non-zero length.
// Wait for a rising edge on the asynchronous trigger.
// Stream that many A/B sample pairs through a single-entry output register.
// Signal completion.
// Samples that arrive while the output register is stalled are dropped and flagged.
//
// Ports:
//   clk_i, rst_i             clock, asynchronous active-high reset
//   arm_i, abort_i           control requests, sampled each edge
//   trig_async_i             trigger, asynchronous to clk_i
//   len_i                    samples per capture, latched at arm
//   adc_a_i, adc_b_i         channel samples, qualified by adc_valid_i (no backpressure)
//   m_tdata_o                {zext16(adc_b), zext16(adc_a)}
//   m_tvalid_o, m_tlast_o    stream valid / final beat of capture
//   m_tready_i               stream ready
//   armed_o, busy_o, done_o  status: ARMED; ARMED/CAPTURE/DRAIN; one-cycle completion pulse
//   overflow_o               sticky dropped-sample flag for the current/last capture
module adc_capture_ctrl #(
  parameter int unsigned DATA_W = 14,
  parameter int unsigned LEN_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              arm_i,
  input  logic              abort_i,
  input  logic              trig_async_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic [DATA_W-1:0] adc_a_i,
  input  logic [DATA_W-1:0] adc_b_i,
  input  logic              adc_valid_i,
  output logic [31:0]       m_tdata_o,
  output logic              m_tvalid_o,
  input  logic              m_tready_i,
  output logic              m_tlast_o,
  output logic              armed_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              overflow_o
);

  typedef enum logic [2:0] {StIdle, StArmed, StCapture, StDrain, StDone} state_e;

  state_e           state_q, state_d;
  logic             trig_meta_q, trig_sync_q, trig_prev_q, trig_pulse_q;
  logic [2:0]       warm_q;
  logic [LEN_W-1:0] len_q, len_d, cnt_q, cnt_d, cnt_inc;
  logic [31:0]      data_q, data_d;
  logic             tvalid_q, tvalid_d, tlast_q, tlast_d, ovf_q, ovf_d;
  logic             armed_q, busy_q, done_q;
  logic             accept;

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    ovf_d    = ovf_q;
    accept   = adc_valid_i && (!tvalid_q || m_tready_i);
    cnt_inc  = cnt_q + LEN_W'(1);

    // Consumed beat empties the register; a same-edge load below overrides this.
    if (tvalid_q && m_tready_i) begin
      tvalid_d = 1'b0;
      tlast_d  = 1'b0;
    end

    if (abort_i && (state_q != StIdle)) begin
      state_d  = StIdle;
      tvalid_d = 1'b0;
      tlast_d  = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (arm_i && !abort_i && (len_i != '0)) begin
            state_d = StArmed;
            len_d   = len_i;
            cnt_d   = '0;
            ovf_d   = 1'b0;
          end
        end
        StArmed: begin
          if (trig_pulse_q) state_d = StCapture;
        end
        StCapture: begin
          if (adc_valid_i) begin
            if (accept) begin
              data_d   = {16'(adc_b_i), 16'(adc_a_i)};
              tvalid_d = 1'b1;
              cnt_d    = cnt_inc;
              // cnt_q < len_q always holds here, so cnt_inc never wraps.
              tlast_d  = (cnt_inc == len_q);
              if (cnt_inc == len_q) state_d = StDrain;
            end else begin
              ovf_d = 1'b1;
            end
          end
        end
        StDrain: begin
          if (!tvalid_q || m_tready_i) state_d = StDone;
        end
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      trig_meta_q  <= 1'b0;
      trig_sync_q  <= 1'b0;
      trig_prev_q  <= 1'b0;
      trig_pulse_q <= 1'b0;
      warm_q       <= '0;
      state_q      <= StIdle;
      len_q        <= '0;
      cnt_q        <= '0;
      data_q       <= '0;
      tvalid_q     <= 1'b0;
      tlast_q      <= 1'b0;
      ovf_q        <= 1'b0;
      armed_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      trig_meta_q  <= trig_async_i;
      trig_sync_q  <= trig_meta_q;
      trig_prev_q  <= trig_sync_q;
      // warm_q[2] marks trig_prev_q as holding a real post-reset sample, so a level
      // already high across reset release is never mistaken for a rising edge.
      warm_q       <= {warm_q[1:0], 1'b1};
      trig_pulse_q <= trig_sync_q & ~trig_prev_q & warm_q[2];
      state_q      <= state_d;
      len_q        <= len_d;
      cnt_q        <= cnt_d;
      data_q       <= data_d;
      tvalid_q     <= tvalid_d;
      tlast_q      <= tlast_d;
      ovf_q        <= ovf_d;
      armed_q      <= (state_d == StArmed);
      busy_q       <= (state_d == StArmed) || (state_d == StCapture) || (state_d == StDrain);
      done_q       <= (state_d == StDone);
    end
  end

  assign m_tdata_o  = data_q;
  assign m_tvalid_o = tvalid_q;
  assign m_tlast_o  = tlast_q;
  assign armed_o    = armed_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign overflow_o = ovf_q;

endmodule

// File: doc/adc_capture_ctrl.md
ADC_CAPTURE_CTRL -- requirements
Module: adc_capture_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 14: ADC sample width per channel, legal range 1..16.
REQ-002 SHALL have parameter LEN_W, default 16: capture-length counter width.
REQ-003 clk_i  in  1  sole clock; all logic on rising edge.
REQ-004 rst_i  in  1  reset, asynchronous, active-high.
REQ-005 arm_i  in  1  arm request, sampled each edge.
REQ-006 abort_i  in  1  abort request, sampled each edge.
REQ-007 trig_async_i  in  1  trigger, asynchronous to clk_i.
REQ-008 len_i  in  LEN_W  samples per capture, latched at arm.
REQ-009 adc_a_i  in  DATA_W  channel A sample.
REQ-010 adc_b_i  in  DATA_W  channel B sample.
REQ-011 adc_valid_i  in  1  A/B samples valid this cycle; no backpressure.
REQ-012 m_tdata_o  out  32  {zero-ext adc_b to 16, zero-ext adc_a to 16}.
REQ-013 m_tvalid_o  out  1  stream valid.
REQ-014 m_tready_i  in  1  stream ready.
REQ-015 m_tlast_o  out  1  marks final sample of capture.
REQ-016 armed_o  out  1  high in ARMED.
REQ-017 busy_o  out  1  high in ARMED, CAPTURE, DRAIN.
REQ-018 done_o  out  1  one-cycle completion pulse.
REQ-019 overflow_o  out  1  sticky: sample dropped during current/last capture.

Function
REQ-020 Trigger path: 2-flop synchronizer then rising-edge detect; trig_async_i high from before edge k produces an internal one-cycle trig pulse during cycle k+2..k+3; a constant level produces no further pulses.
REQ-021 FSM states IDLE, ARMED, CAPTURE, DRAIN, DONE; one-hot or binary at implementer's choice.
REQ-022 IDLE: arm_i=1 and len_i!=0 -> ARMED, latch len_i, clear overflow_o and sample count; arm_i with len_i=0 ignored.
REQ-023 ARMED: trig pulse -> CAPTURE at next edge (edge k+3 for REQ-020 timing); pulses in IDLE, CAPTURE, DRAIN, DONE ignored.
REQ-024 CAPTURE: at each edge with adc_valid_i=1, sample accepted if output register empty or m_tready_i=1; accepted sample loaded into m_tdata_o, m_tvalid_o set, count+1.
REQ-025 Sample with adc_valid_i=1 while m_tvalid_o=1 and m_tready_i=0: dropped, count unchanged, overflow_o set.
REQ-026 m_tlast_o SHALL be 1 with the sample whose acceptance makes count equal latched length; FSM then -> DRAIN.
REQ-027 Output register: m_tvalid_o clears on m_tready_i=1 unless reloaded same edge; m_tdata_o/m_tlast_o stable while m_tvalid_o=1 and m_tready_i=0.
REQ-028 DRAIN: -> DONE at edge where m_tvalid_o=0 or (m_tvalid_o=1 and m_tready_i=1).
REQ-029 DONE: done_o=1 for exactly this one cycle; -> IDLE unconditionally.
REQ-030 abort_i=1 in any non-IDLE state -> IDLE next edge, m_tvalid_o and m_tlast_o cleared, no done_o; overflow_o retained.
REQ-031 Simultaneous abort_i and arm_i: abort wins; arm ignored that cycle.
REQ-032 arm_i in non-IDLE states ignored; len_i changes after arm have no effect.
REQ-033 Count SHALL not wrap: len_i = 2^LEN_W-1 captures exactly that many samples.

Reset
REQ-034 rst_i=1 SHALL immediately force: FSM IDLE, synchronizer/edge flops 0, count 0, m_tvalid_o=0, m_tlast_o=0, m_tdata_o=0, armed_o=0, busy_o=0, done_o=0, overflow_o=0.
REQ-035 Reset mid-capture SHALL discard the output register contents; first edge after release SHALL behave as IDLE.
REQ-036 trig_async_i held high through reset release SHALL NOT generate a trigger pulse.

Verification
REQ-037 len=4, m_tready_i=1, adc_valid_i=1 continuous, trigger edge -> exactly 4 beats, tlast on 4th, done_o one pulse 2 cycles after last acceptance, overflow_o=0.
REQ-038 len=3, m_tready_i=0 for 2 cycles after first beat, adc_valid_i continuous -> first beat held stable, next sample dropped, overflow_o=1, still 3 beats total.
REQ-039 Trigger pulse while IDLE, then arm with len=2, no new trigger -> stays ARMED, no beats; second trigger -> 2 beats.
REQ-040 abort_i asserted in CAPTURE after 2 of 8 beats -> IDLE next edge, m_tvalid_o=0, no done_o, busy_o=0.
REQ-041 rst_i pulsed asynchronously mid-capture with trig_async_i held high -> all outputs 0 immediately; after release arm len=1 -> remains ARMED until fresh trigger edge.
REQ-042 arm with len_i=0 -> stays IDLE, busy_o=0; arm and abort same cycle in IDLE -> stays IDLE.
